cv32e40p_x_if_arbiter: RTL and testbench
========================================

Name: cv32e40p_x_if_arbiter

Overview:
Shares one X-interface accelerator (fpu_ss-style) among NUM_REQ issuing cores or harts. The offload-request channel is arbitrated round-robin with a per-requester outstanding limit. Each granted request is tagged with the requester index on the accelerator hart_id, and each result is routed back to its requester using the returned hart_id. The block sits between the cores' X-interface ports and the accelerator wrapper. The memory channel is out of scope and passes through elsewhere.

Parameters:
NUM_REQ, 2, number of requesters (2..8).
MAX_OUTSTANDING, 4, maximum accepted-but-unanswered instructions per requester (1..15).
HART_ID_W, 32, width of the accelerator hart_id fields.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_q_valid_i  in  NUM_REQ  per-requester request valid
req_q_ready_o  out  NUM_REQ  per-requester request ready
req_q_instr_data_i  in  NUM_REQ x 32  instruction word
req_q_rs_i  in  NUM_REQ x 3 x 32  source operands
req_q_rs_valid_i  in  NUM_REQ x 3  operand valid flags
req_q_rd_clean_i  in  NUM_REQ  rd scoreboard clean
req_k_accept_o  out  NUM_REQ  accept, valid during the handshake cycle only
req_k_is_mem_op_o  out  NUM_REQ  mem-op flag, same qualification
req_k_writeback_o  out  NUM_REQ  writeback flag, same qualification
req_p_valid_o  out  NUM_REQ  routed response valid
req_p_ready_i  in  NUM_REQ  requester response ready
req_p_rd_o  out  5  response rd, shared bus
req_p_data_o  out  32  response data, shared bus
req_p_dualwb_o  out  1  response dual writeback, shared bus
req_p_error_o  out  1  response error, shared bus
acc_q_valid_o  out  1  request valid to accelerator
acc_q_ready_i  in  1  accelerator request ready
acc_q_instr_data_o / acc_q_rs_o / acc_q_rs_valid_o / acc_q_rd_clean_o  out  32 / 3x32 / 3 / 1  muxed from the granted requester
acc_q_hart_id_o  out  HART_ID_W  granted index, zero-extended
acc_k_accept_i / acc_k_is_mem_op_i / acc_k_writeback_i  in  1 each  accelerator decode result
acc_p_valid_i  in  1  accelerator response valid
acc_p_ready_o  out  1  ready to accelerator
acc_p_hart_id_i  in  HART_ID_W  response tag
acc_p_rd_i / acc_p_data_i / acc_p_dualwb_i / acc_p_error_i  in  5 / 32 / 1 / 1  response payload
busy_o  out  1  any outstanding count nonzero
tag_err_o  out  1  sticky: response arrived with an invalid tag

Behaviour:
- Eligibility: requester i is eligible when req_q_valid_i[i] is high and cnt[i] < MAX_OUTSTANDING.
- Arbitration: round-robin starting from pointer rr_q (reset 0). The first eligible index at or after rr_q, wrapping, is granted.
- Grant is combinational, with no added latency.
  - acc_q_valid_o is high when any requester is eligible.
  - acc_q payload is muxed from the granted requester.
  - req_q_ready_o[g] = acc_q_ready_i. All other ready bits are 0.
- Lock: if acc_q_valid_o is high and acc_q_ready_i is low, set lock_q and store the granted index in lock_idx_q.
  - While lock_q is set, the grant is forced to lock_idx_q regardless of rr_q and new arrivals.
  - Eligibility of the locked requester is not re-evaluated while locked.
  - Lock clears on the handshake.
  - Requesters must hold valid and payload stable while locked; a bench assertion checks this.
- Handshake (acc_q_valid_o high and acc_q_ready_i high):
  - req_k_*_o[g] = acc_k_*_i. All other req_k bits are 0.
  - rr_q <= (g+1) mod NUM_REQ.
  - If acc_k_accept_i is high, cnt[g] increments.
- Response routing:
  - t = acc_p_hart_id_i.
  - If t < NUM_REQ: req_p_valid_o[t] = acc_p_valid_i and acc_p_ready_o = req_p_ready_i[t].
  - If t >= NUM_REQ: acc_p_ready_o = 1 (response is dropped), no req_p_valid_o bit asserts, and tag_err_o sets on a valid response.
  - Payload buses are broadcast unregistered.
  - A response handshake with a valid t decrements cnt[t].
- Counters: width is clog2(MAX_OUTSTANDING+1).
  - Increment and decrement of the same counter in one cycle leaves it unchanged.
  - A decrement at 0 saturates at 0 and sets tag_err_o.
  - An increment never exceeds MAX_OUTSTANDING, because eligibility gates it.
- busy_o is the OR of cnt[i] != 0 over all requesters.
- Reset (asynchronous, any time, including mid-lock):
  - rr_q=0, lock_q=0, lock_idx_q=0, all cnt=0, tag_err_o=0.
  - All outputs fall to 0 as a combinational consequence. acc_p_ready_o then follows the routed req_p_ready_i.
  - A transaction in flight at reset is abandoned. No recovery is attempted.

Test Plan:
1. NUM_REQ=2, both valid every cycle, acc_q_ready_i=1, accept=1, responses returned at once → grants alternate 0,1,0,1; acc_q_hart_id_o alternates 0,1.
2. Req0 valid, acc_q_ready_i low for 3 cycles, req1 raises valid in cycle 2 → grant stays on 0 for all 4 cycles; req_q_ready_o[1]=0; after the handshake rr_q=1 and req1 is granted next.
3. MAX_OUTSTANDING=4, req0 issues 4 accepted instructions with no responses → 5th request blocked (acc_q_valid_o=0 if req1 idle); one response with hart_id=0 → cnt0=3 and req0 is granted the next cycle.
4. acc_k_accept_i=0 on a handshake → req_k_accept_o[g]=0 and cnt unchanged; the non-granted requester's k outputs stay 0.
5. Response with hart_id=1 while req_p_ready_i[1]=0 for 2 cycles → req_p_valid_o=2'b10, acc_p_ready_o=0 until ready rises; then cnt1 decrements. In the same cycle, a req1 accept → cnt1 unchanged.
6. Response with hart_id=5 (NUM_REQ=2) → acc_p_ready_o=1, no req_p_valid_o, tag_err_o=1 and holds; assert rst_i mid-lock → all counters and tag_err_o 0 immediately, busy_o=0.

Source files
------------

// File: rtl/cv32e40p_x_if_arbiter.sv
// Shares one X-interface accelerator among NUM_REQ requesters. The offload-request
// channel is arbitrated round-robin, and each requester has a limit on accepted but
// unanswered instructions. Requests are tagged with the requester index on hart_id,
// and responses are routed back to the requester by their returned hart_id.
module cv32e40p_x_if_arbiter #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned HART_ID_W       = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_REQ-1:0]                req_q_valid_i,
    output logic [NUM_REQ-1:0]                req_q_ready_o,
    input  logic [NUM_REQ-1:0][31:0]          req_q_instr_data_i,
    input  logic [NUM_REQ-1:0][2:0][31:0]     req_q_rs_i,
    input  logic [NUM_REQ-1:0][2:0]           req_q_rs_valid_i,
    input  logic [NUM_REQ-1:0]                req_q_rd_clean_i,
    output logic [NUM_REQ-1:0]                req_k_accept_o,
    output logic [NUM_REQ-1:0]                req_k_is_mem_op_o,
    output logic [NUM_REQ-1:0]                req_k_writeback_o,
    output logic [NUM_REQ-1:0]                req_p_valid_o,
    input  logic [NUM_REQ-1:0]                req_p_ready_i,
    output logic [4:0]                        req_p_rd_o,
    output logic [31:0]                       req_p_data_o,
    output logic                              req_p_dualwb_o,
    output logic                              req_p_error_o,
    output logic                              acc_q_valid_o,
    input  logic                              acc_q_ready_i,
    output logic [31:0]                       acc_q_instr_data_o,
    output logic [2:0][31:0]                  acc_q_rs_o,
    output logic [2:0]                        acc_q_rs_valid_o,
    output logic                              acc_q_rd_clean_o,
    output logic [HART_ID_W-1:0]              acc_q_hart_id_o,
    input  logic                              acc_k_accept_i,
    input  logic                              acc_k_is_mem_op_i,
    input  logic                              acc_k_writeback_i,
    input  logic                              acc_p_valid_i,
    output logic                              acc_p_ready_o,
    input  logic [HART_ID_W-1:0]              acc_p_hart_id_i,
    input  logic [4:0]                        acc_p_rd_i,
    input  logic [31:0]                       acc_p_data_i,
    input  logic                              acc_p_dualwb_i,
    input  logic                              acc_p_error_i,
    output logic                              busy_o,
    output logic                              tag_err_o
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [CNT_W-1:0]   cnt_reg [NUM_REQ];
    logic [IDX_W-1:0]   rr_reg;
    logic [IDX_W-1:0]   rr_next;
    logic [IDX_W-1:0]   lock_idx_reg;
    logic               lock_reg;
    logic               tag_err_reg;

    logic [NUM_REQ-1:0] eligible;
    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic               q_hs;
    logic               tag_ok;
    logic [IDX_W-1:0]   resp_idx;
    logic [NUM_REQ-1:0] cnt_inc;
    logic [NUM_REQ-1:0] cnt_dec;
    logic [NUM_REQ-1:0] cnt_underflow;
    logic [NUM_REQ-1:0] cnt_nonzero;

    // Per-requester eligibility, rotated candidate order and outstanding counters
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [IDX_W:0] cand_sum;

            assign eligible[gi] = req_q_valid_i[gi] && (cnt_reg[gi] < CNT_MAX);

            // Requester checked at offset gi from the round-robin pointer
            assign cand_sum     = {1'b0, rr_reg} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (cand_sum >= (IDX_W+1)'(NUM_REQ))
                                ? IDX_W'(cand_sum - (IDX_W+1)'(NUM_REQ))
                                : IDX_W'(cand_sum);

            assign cnt_inc[gi] = q_hs && acc_k_accept_i && (gnt_idx == IDX_W'(gi));
            assign cnt_dec[gi] = acc_p_valid_i && acc_p_ready_o && tag_ok
                              && (resp_idx == IDX_W'(gi));
            // A response for a requester with nothing outstanding is a tagging error
            assign cnt_underflow[gi] = cnt_dec[gi] && !cnt_inc[gi] && (cnt_reg[gi] == '0);
            assign cnt_nonzero[gi]   = (cnt_reg[gi] != '0);

            // Outstanding counter: simultaneous issue and retire cancel out
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && !cnt_dec[gi]) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end else if (cnt_dec[gi] && !cnt_inc[gi] && (cnt_reg[gi] != '0)) begin
                    cnt_reg[gi] <= cnt_reg[gi] - 1'b1;
                end
            end
        end
    endgenerate

    // Grant: the locked requester if a request is stalled, else the first eligible
    // requester at or after the pointer (scanned backwards so the lowest offset wins)
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = rr_reg;
        if (lock_reg) begin
            gnt_valid = 1'b1;
            gnt_idx   = lock_idx_reg;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (eligible[cand_idx[k]]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = cand_idx[k];
                end
            end
        end
    end

    assign q_hs    = gnt_valid && acc_q_ready_i;
    assign rr_next = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

    assign acc_q_valid_o      = gnt_valid;
    assign acc_q_instr_data_o = req_q_instr_data_i[gnt_idx];
    assign acc_q_rs_o         = req_q_rs_i[gnt_idx];
    assign acc_q_rs_valid_o   = req_q_rs_valid_i[gnt_idx];
    assign acc_q_rd_clean_o   = req_q_rd_clean_i[gnt_idx];
    assign acc_q_hart_id_o    = HART_ID_W'(gnt_idx);

    // Response tag decode; out-of-range tags are dropped by the arbiter itself
    assign tag_ok   = (acc_p_hart_id_i < HART_ID_W'(NUM_REQ));
    assign resp_idx = acc_p_hart_id_i[IDX_W-1:0];

    // Per-requester steering of ready, decode results and response valid
    always_comb begin
        req_q_ready_o     = '0;
        req_k_accept_o    = '0;
        req_k_is_mem_op_o = '0;
        req_k_writeback_o = '0;
        req_p_valid_o     = '0;
        acc_p_ready_o     = 1'b1;
        if (gnt_valid) begin
            req_q_ready_o[gnt_idx] = acc_q_ready_i;
        end
        if (q_hs) begin
            req_k_accept_o[gnt_idx]    = acc_k_accept_i;
            req_k_is_mem_op_o[gnt_idx] = acc_k_is_mem_op_i;
            req_k_writeback_o[gnt_idx] = acc_k_writeback_i;
        end
        if (tag_ok) begin
            req_p_valid_o[resp_idx] = acc_p_valid_i;
            acc_p_ready_o           = req_p_ready_i[resp_idx];
        end
    end

    assign req_p_rd_o     = acc_p_rd_i;
    assign req_p_data_o   = acc_p_data_i;
    assign req_p_dualwb_o = acc_p_dualwb_i;
    assign req_p_error_o  = acc_p_error_i;

    assign busy_o    = |cnt_nonzero;
    assign tag_err_o = tag_err_reg;

    // Round-robin pointer, stall lock and sticky tag error
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_reg       <= '0;
            lock_reg     <= 1'b0;
            lock_idx_reg <= '0;
            tag_err_reg  <= 1'b0;
        end else begin
            if (q_hs) begin
                rr_reg <= rr_next;
            end
            if (gnt_valid && !acc_q_ready_i) begin
                lock_reg     <= 1'b1;
                lock_idx_reg <= gnt_idx;
            end else if (q_hs) begin
                lock_reg <= 1'b0;
            end
            if ((acc_p_valid_i && !tag_ok) || (|cnt_underflow)) begin
                tag_err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_x_if_arbiter.sv
// Bench for cv32e40p_x_if_arbiter: directed scenarios plus a randomized run checked
// against a behavioural model of grants, outstanding counts and the sticky tag error.
module tb_cv32e40p_x_if_arbiter;

    localparam int N   = 2;
    localparam int MAX = 4;
    localparam int HW  = 32;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [N-1:0]           req_q_valid_i;
    logic [N-1:0]           req_q_ready_o;
    logic [N-1:0][31:0]     req_q_instr_data_i;
    logic [N-1:0][2:0][31:0] req_q_rs_i;
    logic [N-1:0][2:0]      req_q_rs_valid_i;
    logic [N-1:0]           req_q_rd_clean_i;
    logic [N-1:0]           req_k_accept_o;
    logic [N-1:0]           req_k_is_mem_op_o;
    logic [N-1:0]           req_k_writeback_o;
    logic [N-1:0]           req_p_valid_o;
    logic [N-1:0]           req_p_ready_i;
    logic [4:0]             req_p_rd_o;
    logic [31:0]            req_p_data_o;
    logic                   req_p_dualwb_o;
    logic                   req_p_error_o;
    logic                   acc_q_valid_o;
    logic                   acc_q_ready_i;
    logic [31:0]            acc_q_instr_data_o;
    logic [2:0][31:0]       acc_q_rs_o;
    logic [2:0]             acc_q_rs_valid_o;
    logic                   acc_q_rd_clean_o;
    logic [HW-1:0]          acc_q_hart_id_o;
    logic                   acc_k_accept_i;
    logic                   acc_k_is_mem_op_i;
    logic                   acc_k_writeback_i;
    logic                   acc_p_valid_i;
    logic                   acc_p_ready_o;
    logic [HW-1:0]          acc_p_hart_id_i;
    logic [4:0]             acc_p_rd_i;
    logic [31:0]            acc_p_data_i;
    logic                   acc_p_dualwb_i;
    logic                   acc_p_error_i;
    logic                   busy_o;
    logic                   tag_err_o;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int   m_cnt [N];
    int   m_rr;
    bit   m_lock;
    int   m_lidx;
    bit   m_terr;
    logic [31:0] m_held_instr;

    cv32e40p_x_if_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MAX), .HART_ID_W(HW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_q_valid_i(req_q_valid_i), .req_q_ready_o(req_q_ready_o),
        .req_q_instr_data_i(req_q_instr_data_i), .req_q_rs_i(req_q_rs_i),
        .req_q_rs_valid_i(req_q_rs_valid_i), .req_q_rd_clean_i(req_q_rd_clean_i),
        .req_k_accept_o(req_k_accept_o), .req_k_is_mem_op_o(req_k_is_mem_op_o),
        .req_k_writeback_o(req_k_writeback_o), .req_p_valid_o(req_p_valid_o),
        .req_p_ready_i(req_p_ready_i), .req_p_rd_o(req_p_rd_o), .req_p_data_o(req_p_data_o),
        .req_p_dualwb_o(req_p_dualwb_o), .req_p_error_o(req_p_error_o),
        .acc_q_valid_o(acc_q_valid_o), .acc_q_ready_i(acc_q_ready_i),
        .acc_q_instr_data_o(acc_q_instr_data_o), .acc_q_rs_o(acc_q_rs_o),
        .acc_q_rs_valid_o(acc_q_rs_valid_o), .acc_q_rd_clean_o(acc_q_rd_clean_o),
        .acc_q_hart_id_o(acc_q_hart_id_o), .acc_k_accept_i(acc_k_accept_i),
        .acc_k_is_mem_op_i(acc_k_is_mem_op_i), .acc_k_writeback_i(acc_k_writeback_i),
        .acc_p_valid_i(acc_p_valid_i), .acc_p_ready_o(acc_p_ready_o),
        .acc_p_hart_id_i(acc_p_hart_id_i), .acc_p_rd_i(acc_p_rd_i), .acc_p_data_i(acc_p_data_i),
        .acc_p_dualwb_i(acc_p_dualwb_i), .acc_p_error_i(acc_p_error_i),
        .busy_o(busy_o), .tag_err_o(tag_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Model: which requester should own the request channel right now
    function automatic void m_grant(output bit v, output int g);
        v = 1'b0;
        g = 0;
        if (m_lock) begin
            v = 1'b1;
            g = m_lidx;
        end else begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_rr + k) % N;
                if (req_q_valid_i[i] && m_cnt[i] < MAX) begin
                    v = 1'b1;
                    g = i;
                    return;
                end
            end
        end
    endfunction

    task automatic idle();
        req_q_valid_i      = '0;
        req_q_instr_data_i = '0;
        req_q_rs_i         = '0;
        req_q_rs_valid_i   = '0;
        req_q_rd_clean_i   = '0;
        req_p_ready_i      = '0;
        acc_q_ready_i      = 1'b0;
        acc_k_accept_i     = 1'b0;
        acc_k_is_mem_op_i  = 1'b0;
        acc_k_writeback_i  = 1'b0;
        acc_p_valid_i      = 1'b0;
        acc_p_hart_id_i    = '0;
        acc_p_rd_i         = '0;
        acc_p_data_i       = '0;
        acc_p_dualwb_i     = 1'b0;
        acc_p_error_i      = 1'b0;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge
    task automatic tick();
        bit v;
        int g;
        int c;
        int n_cnt [N];
        int n_rr;
        bit n_lock;
        int n_lidx;
        bit n_terr;
        if (m_lock) begin
            assert (req_q_valid_i[m_lidx] && req_q_instr_data_i[m_lidx] == m_held_instr)
                else $error("locked requester %0d changed its request", m_lidx);
        end
        m_grant(v, g);
        n_rr = m_rr; n_lock = m_lock; n_lidx = m_lidx; n_terr = m_terr;
        for (int i = 0; i < N; i++) begin
            c = m_cnt[i];
            if (v && acc_q_ready_i && acc_k_accept_i && g == i) c++;
            if (acc_p_valid_i && acc_p_hart_id_i == i && req_p_ready_i[i]) c--;
            if (c < 0) begin c = 0; n_terr = 1'b1; end
            n_cnt[i] = c;
        end
        if (acc_p_valid_i && acc_p_hart_id_i >= N) n_terr = 1'b1;
        if (v && !acc_q_ready_i) begin
            n_lock = 1'b1; n_lidx = g; m_held_instr = req_q_instr_data_i[g];
        end else if (v) begin
            n_lock = 1'b0; n_rr = (g + 1) % N;
        end
        @(posedge clk_i);
        m_cnt = n_cnt; m_rr = n_rr; m_lock = n_lock; m_lidx = n_lidx; m_terr = n_terr;
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        idle();
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_rr = 0; m_lock = 1'b0; m_lidx = 0; m_terr = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total += 5;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        if (tag_err_o !== 1'b0) begin bad++; $display("FAIL reset_tag_err got=%b want=0", tag_err_o); end
        if (acc_q_valid_o !== 1'b0) begin bad++; $display("FAIL reset_q_valid got=%b want=0", acc_q_valid_o); end
        if (req_p_valid_o !== 2'b00) begin bad++; $display("FAIL reset_p_valid got=%b want=00", req_p_valid_o); end
        if (acc_p_ready_o !== 1'b0) begin bad++; $display("FAIL reset_p_ready got=%b want=0", acc_p_ready_o); end
        $display("test_reset: busy=%b tag_err=%b", busy_o, tag_err_o);
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req_q_valid_i = 2'b11;
            req_q_instr_data_i[0] = 32'h1000 + k;
            req_q_instr_data_i[1] = 32'h2000 + k;
            acc_q_ready_i = 1'b1; acc_k_accept_i = 1'b1;
            req_p_ready_i = 2'b11;
            acc_p_valid_i = (k > 0);
            acc_p_hart_id_i = HW'((k + 1) % 2);
            #1;
            total += 3;
            if (acc_q_hart_id_o !== HW'(k % 2)) begin bad++; $display("FAIL rr_hart_id cyc=%0d got=%0d want=%0d", k, acc_q_hart_id_o, k % 2); end
            if (req_q_ready_o !== 2'(1 << (k % 2))) begin bad++; $display("FAIL rr_ready cyc=%0d got=%b", k, req_q_ready_o); end
            if (acc_q_instr_data_o !== req_q_instr_data_i[k % 2]) begin bad++; $display("FAIL rr_payload cyc=%0d got=%h", k, acc_q_instr_data_o); end
            $display("test_round_robin: cyc=%0d hart_id=%0d instr=%h", k, acc_q_hart_id_o, acc_q_instr_data_o);
            tick();
        end
    endtask

    task automatic test_lock();
        do_reset();
        // One non-accepted handshake from req0 moves the pointer to 1
        req_q_valid_i = 2'b01; acc_q_ready_i = 1'b1; acc_k_accept_i = 1'b0;
        tick();
        req_q_instr_data_i[0] = 32'hAAAA_0000;
        req_q_instr_data_i[1] = 32'hBBBB_0000;
        for (int c = 0; c < 4; c++) begin
            req_q_valid_i = (c >= 1) ? 2'b11 : 2'b01;
            acc_q_ready_i = (c == 3);
            acc_k_accept_i = 1'b0;
            #1;
            total += 2;
            if (acc_q_hart_id_o !== '0 || acc_q_valid_o !== 1'b1) begin bad++; $display("FAIL lock_grant cyc=%0d got=%0d want=0", c, acc_q_hart_id_o); end
            if (req_q_ready_o !== ((c == 3) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL lock_ready cyc=%0d got=%b", c, req_q_ready_o); end
            $display("test_lock: cyc=%0d hart_id=%0d ready=%b", c, acc_q_hart_id_o, req_q_ready_o);
            tick();
        end
        req_q_valid_i = 2'b11; acc_q_ready_i = 1'b1;
        #1;
        total++;
        if (acc_q_hart_id_o !== HW'(1)) begin bad++; $display("FAIL lock_after got=%0d want=1", acc_q_hart_id_o); end
        $display("test_lock: after handshake hart_id=%0d", acc_q_hart_id_o);
        tick();
    endtask

    task automatic test_outstanding();
        do_reset();
        req_q_valid_i = 2'b01; acc_q_ready_i = 1'b1; acc_k_accept_i = 1'b1;
        for (int k = 0; k < MAX; k++) begin
            #1;
            total++;
            if (acc_q_valid_o !== 1'b1) begin bad++; $display("FAIL limit_issue n=%0d got=%b want=1", k, acc_q_valid_o); end
            tick();
        end
        #1;
        total += 3;
        if (acc_q_valid_o !== 1'b0) begin bad++; $display("FAIL limit_block got=%b want=0", acc_q_valid_o); end
        if (req_q_ready_o !== 2'b00) begin bad++; $display("FAIL limit_ready got=%b want=00", req_q_ready_o); end
        if (busy_o !== 1'b1) begin bad++; $display("FAIL limit_busy got=%b want=1", busy_o); end
        acc_p_valid_i = 1'b1; acc_p_hart_id_i = '0; req_p_ready_i = 2'b01;
        #1;
        total += 3;
        if (acc_q_valid_o !== 1'b0) begin bad++; $display("FAIL limit_same_cycle got=%b want=0", acc_q_valid_o); end
        if (acc_p_ready_o !== 1'b1) begin bad++; $display("FAIL limit_p_ready got=%b want=1", acc_p_ready_o); end
        if (req_p_valid_o !== 2'b01) begin bad++; $display("FAIL limit_p_valid got=%b want=01", req_p_valid_o); end
        tick();
        acc_p_valid_i = 1'b0;
        #1;
        total++;
        if (acc_q_valid_o !== 1'b1 || acc_q_hart_id_o !== '0) begin bad++; $display("FAIL limit_resume got=%b/%0d want=1/0", acc_q_valid_o, acc_q_hart_id_o); end
        $display("test_outstanding: resumed valid=%b hart_id=%0d", acc_q_valid_o, acc_q_hart_id_o);
        tick();
    endtask

    task automatic test_no_accept();
        do_reset();
        req_q_valid_i = 2'b11; acc_q_ready_i = 1'b1;
        acc_k_accept_i = 1'b0; acc_k_is_mem_op_i = 1'b1; acc_k_writeback_i = 1'b1;
        #1;
        total += 3;
        if (req_k_accept_o !== 2'b00) begin bad++; $display("FAIL noacc_accept got=%b want=00", req_k_accept_o); end
        if (req_k_is_mem_op_o !== 2'b01) begin bad++; $display("FAIL noacc_memop got=%b want=01", req_k_is_mem_op_o); end
        if (req_k_writeback_o !== 2'b01) begin bad++; $display("FAIL noacc_wb got=%b want=01", req_k_writeback_o); end
        tick();
        acc_k_accept_i = 1'b1;
        #1;
        total += 2;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL noacc_cnt got=%b want=0", busy_o); end
        if (req_k_accept_o !== 2'b10) begin bad++; $display("FAIL noacc_second got=%b want=10", req_k_accept_o); end
        $display("test_no_accept: k_accept=%b k_memop=%b", req_k_accept_o, req_k_is_mem_op_o);
        tick();
    endtask

    task automatic test_resp_backpressure();
        do_reset();
        req_q_valid_i = 2'b10; acc_q_ready_i = 1'b1; acc_k_accept_i = 1'b1;
        tick();
        idle();
        acc_p_valid_i = 1'b1; acc_p_hart_id_i = HW'(1); acc_p_data_i = 32'hC0FFEE01;
        for (int c = 0; c < 2; c++) begin
            #1;
            total += 3;
            if (req_p_valid_o !== 2'b10) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b want=10", c, req_p_valid_o); end
            if (acc_p_ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b want=0", c, acc_p_ready_o); end
            if (req_p_data_o !== 32'hC0FFEE01) begin bad++; $display("FAIL bp_data got=%h", req_p_data_o); end
            tick();
        end
        req_p_ready_i = 2'b10;
        req_q_valid_i = 2'b10; acc_q_ready_i = 1'b1; acc_k_accept_i = 1'b1;
        #1;
        total++;
        if (acc_p_ready_o !== 1'b1) begin bad++; $display("FAIL bp_release got=%b want=1", acc_p_ready_o); end
        tick();
        idle();
        #1;
        total++;
        if (busy_o !== 1'b1) begin bad++; $display("FAIL bp_inc_dec got=%b want=1", busy_o); end
        acc_p_valid_i = 1'b1; acc_p_hart_id_i = HW'(1); req_p_ready_i = 2'b10;
        tick();
        idle();
        #1;
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", busy_o); end
        $display("test_resp_backpressure: busy=%b", busy_o);
    endtask

    task automatic test_bad_tag_and_reset();
        do_reset();
        acc_p_valid_i = 1'b1; acc_p_hart_id_i = HW'(5); req_p_ready_i = 2'b00;
        #1;
        total += 2;
        if (acc_p_ready_o !== 1'b1) begin bad++; $display("FAIL badtag_ready got=%b want=1", acc_p_ready_o); end
        if (req_p_valid_o !== 2'b00) begin bad++; $display("FAIL badtag_valid got=%b want=00", req_p_valid_o); end
        tick();
        idle();
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if (tag_err_o !== 1'b1) begin bad++; $display("FAIL badtag_sticky cyc=%0d got=%b want=1", c, tag_err_o); end
            tick();
        end
        req_q_valid_i = 2'b01; req_q_instr_data_i[0] = 32'h5555; acc_q_ready_i = 1'b1; acc_k_accept_i = 1'b1;
        tick();
        acc_q_ready_i = 1'b0;
        tick();
        #2;
        rst_i = 1'b1;
        #1;
        total += 3;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy_o); end
        if (tag_err_o !== 1'b0) begin bad++; $display("FAIL rst_tag_err got=%b want=0", tag_err_o); end
        if (acc_q_hart_id_o !== '0) begin bad++; $display("FAIL rst_hart_id got=%0d want=0", acc_q_hart_id_o); end
        $display("test_bad_tag_and_reset: busy=%b tag_err=%b", busy_o, tag_err_o);
        do_reset();
    endtask

    task automatic test_random();
        bit v;
        int g;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_acc;
        logic [N-1:0] exp_pv;
        logic         exp_pr;
        int t;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!(m_lock && m_lidx == i)) begin
                    req_q_valid_i[i]      = ($urandom_range(0, 9) < 6);
                    req_q_instr_data_i[i] = $urandom;
                    req_q_rs_i[i][0]      = $urandom;
                    req_q_rd_clean_i[i]   = $urandom_range(0, 1);
                end
            end
            acc_q_ready_i     = ($urandom_range(0, 9) < 7);
            acc_k_accept_i    = ($urandom_range(0, 9) < 8);
            acc_k_is_mem_op_i = $urandom_range(0, 1);
            acc_k_writeback_i = $urandom_range(0, 1);
            req_p_ready_i     = N'($urandom);
            t = $urandom_range(0, N - 1);
            acc_p_valid_i   = (m_cnt[t] > 0) && ($urandom_range(0, 1) == 1);
            acc_p_hart_id_i = HW'(t);
            if ($urandom_range(0, 59) == 0) begin
                acc_p_valid_i = 1'b1; acc_p_hart_id_i = HW'(7);
            end
            #1;
            m_grant(v, g);
            exp_ready = '0; exp_acc = '0; exp_pv = '0; exp_pr = 1'b1;
            if (v) exp_ready[g] = acc_q_ready_i;
            if (v && acc_q_ready_i) exp_acc[g] = acc_k_accept_i;
            if (acc_p_hart_id_i < N) begin
                exp_pv[acc_p_hart_id_i] = acc_p_valid_i;
                exp_pr = req_p_ready_i[acc_p_hart_id_i];
            end
            total += 7;
            if (acc_q_valid_o !== v) begin bad++; $display("FAIL rnd_q_valid cyc=%0d got=%b want=%b", cyc, acc_q_valid_o, v); end
            if (v && (acc_q_hart_id_o !== HW'(g) || acc_q_instr_data_o !== req_q_instr_data_i[g]
                      || acc_q_rs_o[0] !== req_q_rs_i[g][0] || acc_q_rd_clean_o !== req_q_rd_clean_i[g])) begin
                bad++; $display("FAIL rnd_grant cyc=%0d got=%0d want=%0d", cyc, acc_q_hart_id_o, g);
            end
            if (req_q_ready_o !== exp_ready) begin bad++; $display("FAIL rnd_q_ready cyc=%0d got=%b want=%b", cyc, req_q_ready_o, exp_ready); end
            if (req_k_accept_o !== exp_acc) begin bad++; $display("FAIL rnd_k_accept cyc=%0d got=%b want=%b", cyc, req_k_accept_o, exp_acc); end
            if (req_p_valid_o !== exp_pv || acc_p_ready_o !== exp_pr) begin
                bad++; $display("FAIL rnd_resp cyc=%0d got=%b/%b want=%b/%b", cyc, req_p_valid_o, acc_p_ready_o, exp_pv, exp_pr);
            end
            if (busy_o !== ((m_cnt[0] != 0) || (m_cnt[1] != 0))) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b cnt=%0d/%0d", cyc, busy_o, m_cnt[0], m_cnt[1]); end
            if (tag_err_o !== m_terr) begin bad++; $display("FAIL rnd_tag_err cyc=%0d got=%b want=%b", cyc, tag_err_o, m_terr); end
            $display("test_random: cyc=%0d v=%b g=%0d cnt=%0d/%0d", cyc, v, g, m_cnt[0], m_cnt[1]);
            tick();
        end
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        test_reset();
        test_round_robin();
        test_lock();
        test_outstanding();
        test_no_accept();
        test_resp_backpressure();
        test_bad_tag_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
